// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state type
// and the store lane helpers used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Byte-lane enables for a legal, aligned store; illegal sizes get no lanes.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b00:   lane_mask = 4'b0001 << offset;
      2'b01:   lane_mask = offset[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Replicating the store operand lets the mask alone select the target lanes.
  function automatic logic [31:0] lane_data(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3[1:0])
      2'b00:   lane_data = {4{wdata[7:0]}};
      2'b01:   lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
  endfunction

  function automatic logic access_fault(input logic store, input logic [2:0] funct3,
                                        input logic [1:0] offset);
    logic illegal;
    logic misaligned;
    if (store) illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    else       illegal = funct3 inside {3'b011, 3'b110, 3'b111};
    misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                 ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    access_fault = illegal || misaligned;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword/word out of a memory word and sign- or
// zero-extends it according to the RV32I load funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(word_i >> {offset_i, 3'b000});
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      F3_W:    data_o = word_i;
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller driving the data_mem port set.
// Decodes at acceptance, writes for one cycle or waits out the read latency.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              mem_wr,
  output logic [3:0]        mem_masked,
  input  logic [31:0]       mem_r_data
);

  lsu_state_t        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [3:0]        mask_q, mask_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rfault_q, rfault_d;

  logic [31:0]       load_data;
  logic              req_fault;
  logic              unused_addr_hi;

  // Upper address bits wrap by design; they are deliberately dropped.
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_fault = access_fault(req_store, req_funct3, req_addr[1:0]);

  load_extend u_load_extend (
    .word_i   (mem_r_data),
    .funct3_i (f3_q),
    .offset_i (off_q),
    .data_o   (load_data)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    off_d    = off_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = 1'b0;
    mask_d   = 4'b0000;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    rfault_d = rfault_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d   = req_funct3;
          off_d  = req_addr[1:0];
          addr_d = req_addr[ADDR_W+1:2];
          if (req_fault) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rdata_d  = 32'd0;
            rfault_d = 1'b1;
          end else if (req_store) begin
            state_d = WRITE;
            wr_d    = 1'b1;
            mask_d  = lane_mask(req_funct3, req_addr[1:0]);
            wdata_d = lane_data(req_funct3, req_wdata);
          end else begin
            state_d = READ;
            cnt_d   = 3'(MEM_RD_LAT);
          end
        end
      end
      WRITE: begin
        state_d  = RESP;
        rvalid_d = 1'b1;
        rdata_d  = 32'd0;
        rfault_d = 1'b0;
      end
      READ: begin
        // The capture edge is the one on which the count reaches zero.
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rdata_d  = load_data;
          rfault_d = 1'b0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      wr_q     <= 1'b0;
      mask_q   <= 4'b0000;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      mask_q   <= mask_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rfault_q <= rfault_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_fault = rfault_q;
  assign mem_addr   = addr_q;
  assign mem_data   = wdata_q;
  assign mem_wr     = wr_q;
  assign mem_masked = mask_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: a byte-lane memory model with a 3-cycle read path,
// plus response and write scoreboards filled when requests are accepted.
module tb_lsu_mem_ctrl;

  localparam int ADDR_W = 3;
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_store = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              mem_wr;
  logic [3:0]        mem_masked;
  logic [31:0]       mem_r_data;

  lsu_mem_ctrl #(.ADDR_W(ADDR_W), .MEM_RD_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wr     (mem_wr),
    .mem_masked (mem_masked),
    .mem_r_data (mem_r_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational lookup followed by LAT-1 pipeline registers.
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rd_p1 = 32'd0;
  logic [31:0] rd_p2 = 32'd0;
  initial for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 32'd0;
  always @(posedge clk) begin
    if (mem_wr)
      for (int i = 0; i < 4; i++)
        if (mem_masked[i]) mem[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
    rd_p1 <= mem[mem_addr];
    rd_p2 <= rd_p1;
  end
  assign mem_r_data = rd_p2;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          acc;
    int          lat;
  } resp_exp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        mask;
    logic [31:0]       data;
  } wr_exp_t;

  resp_exp_t resp_q[$];
  wr_exp_t   wr_q[$];
  resp_exp_t r_e;
  wr_exp_t   w_e;
  int        last_acc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("mask_without_wr", 32'(mem_masked & ~{4{mem_wr}}), 32'd0);
      if (mem_wr) begin
        if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else begin
          w_e = wr_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(w_e.addr));
          check("wr_mask", 32'(mem_masked), 32'(w_e.mask));
          check("wr_data", mem_data, w_e.data);
        end
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
        else begin
          r_e = resp_q.pop_front();
          check("resp_rdata", resp_rdata, r_e.rdata);
          check("resp_fault", 32'(resp_fault), 32'(r_e.fault));
          check("resp_latency", 32'(cyc - r_e.acc + 1), 32'(r_e.lat));
        end
      end
    end
  end

  // Presents a request (leaving req_valid high) and pushes its expectations at acceptance.
  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_f,
                      input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
    int waited;
    resp_exp_t e;
    wr_exp_t   w;
    waited = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd1, 32'd0);
      return;
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    e.rdata = exp_rd;
    e.fault = exp_f;
    e.acc   = cyc;
    e.lat   = exp_f ? 1 : (st ? 2 : LAT + 1);
    resp_q.push_back(e);
    if (st && !exp_f) begin
      w.addr = a[ADDR_W+1:2];
      w.mask = exp_mask;
      w.data = exp_wdata;
      wr_q.push_back(w);
    end
    check("ready_busy", 32'(req_ready), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_resp", 32'(resp_q.size()), 32'd0);
    check("drain_wr", 32'(wr_q.size()), 32'd0);
  endtask

  int a0, a1, a2;

  initial begin
    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_masked", 32'(mem_masked), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Byte store replicated across lanes, then a full-word preload of word 1.
    send(1'b1, 3'b000, 32'h5, 32'h0000_000E, 32'd0, 1'b0, 4'b0010, 32'h0E0E_0E0E);
    send(1'b1, 3'b010, 32'h4, 32'h80F0_1234, 32'd0, 1'b0, 4'b1111, 32'h80F0_1234);
    send(1'b0, 3'b000, 32'h7, 32'd0, 32'hFFFF_FF80, 1'b0, 4'b0, 32'd0);
    send(1'b0, 3'b100, 32'h7, 32'd0, 32'h0000_0080, 1'b0, 4'b0, 32'd0);
    send(1'b0, 3'b001, 32'h6, 32'd0, 32'hFFFF_80F0, 1'b0, 4'b0, 32'd0);
    send(1'b0, 3'b101, 32'h4, 32'd0, 32'h0000_1234, 1'b0, 4'b0, 32'd0);
    send(1'b0, 3'b010, 32'h4, 32'd0, 32'h80F0_1234, 1'b0, 4'b0, 32'd0);

    // Faults: misaligned SH/LW, illegal store and load encodings.
    send(1'b1, 3'b001, 32'h3, 32'hDEAD_BEEF, 32'd0, 1'b1, 4'b0, 32'd0);
    send(1'b0, 3'b010, 32'h2, 32'd0, 32'd0, 1'b1, 4'b0, 32'd0);
    send(1'b1, 3'b100, 32'h0, 32'h1111_1111, 32'd0, 1'b1, 4'b0, 32'd0);
    send(1'b0, 3'b011, 32'h0, 32'd0, 32'd0, 1'b1, 4'b0, 32'd0);
    drain();

    // Three SW with req_valid held high: accepts three cycles apart.
    send(1'b1, 3'b010, 32'h08, 32'hAAAA_0001, 32'd0, 1'b0, 4'b1111, 32'hAAAA_0001);
    a0 = last_acc;
    send(1'b1, 3'b010, 32'h0C, 32'hBBBB_0002, 32'd0, 1'b0, 4'b1111, 32'hBBBB_0002);
    a1 = last_acc;
    send(1'b1, 3'b010, 32'h10, 32'hCCCC_0003, 32'd0, 1'b0, 4'b1111, 32'hCCCC_0003);
    a2 = last_acc;
    check("b2b_gap01", 32'(a1 - a0), 32'd3);
    check("b2b_gap12", 32'(a2 - a1), 32'd3);

    // Address wrap: 0x20 lands on word 0; then read back the stored words.
    send(1'b1, 3'b010, 32'h20, 32'h1234_5678, 32'd0, 1'b0, 4'b1111, 32'h1234_5678);
    send(1'b0, 3'b010, 32'h20, 32'd0, 32'h1234_5678, 1'b0, 4'b0, 32'd0);
    send(1'b0, 3'b001, 32'hA, 32'd0, 32'hFFFF_AAAA, 1'b0, 4'b0, 32'd0);
    send(1'b0, 3'b100, 32'h10, 32'd0, 32'h0000_0003, 1'b0, 4'b0, 32'd0);
    send(1'b0, 3'b101, 32'hE, 32'd0, 32'h0000_BBBB, 1'b0, 4'b0, 32'd0);
    drain();

    // Reset in the middle of a read: abandoned, no response afterwards.
    send(1'b0, 3'b010, 32'h4, 32'd0, 32'h80F0_1234, 1'b0, 4'b0, 32'd0);
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    resp_q.delete();
    #1;
    check("arst_ready", 32'(req_ready), 32'd1);
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_resp_rdata", resp_rdata, 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_mem_data", mem_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator that drives the data memory (`data_mem`) port set: `addr` / `data` / `wr` / `masked` / `r_data`.
- Accepts one RV32I load or store per request from the core and performs the memory transaction over a small FSM.
- Stores: generates the byte-lane write mask and lane-aligned write data.
- Loads: waits the memory read latency, then extracts and sign- or zero-extends the addressed byte, halfword or word.
- Sits between the execute stage and `data_mem`.

Parameters:
- `ADDR_W`, 3: word-index width of the memory address port.
- `MEM_RD_LAT`, 1: cycles from `mem_addr` being driven (with `mem_wr`=0) to `mem_r_data` being valid. Legal range 1..7.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  controller can accept a request.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, taken from the low bits.
- `resp_valid`  out  1  one-cycle pulse, response available.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  access was misaligned or had an illegal funct3.
- `mem_addr`  out  ADDR_W  word index, equal to `req_addr[ADDR_W+1:2]`.
- `mem_data`  out  32  write data to memory.
- `mem_wr`  out  1  write strobe.
- `mem_masked`  out  4  byte-lane enables; bit *i* covers `mem_data[8i+7:8i]`.
- `mem_r_data`  in  32  read data from memory.

Behaviour:
- Reset, asynchronous on `rst_n`=0:
  - state = IDLE.
  - All outputs 0 except `req_ready`=1.
  - The latency counter is cleared.
  - A transaction interrupted by reset is abandoned: no response, and `mem_wr` drops immediately.
- Every output is registered, except `req_ready`, which equals (state==IDLE).
- Handshake:
  - A request is accepted on a rising edge with `req_valid` && `req_ready`.
  - `req_*` are captured at acceptance; later changes are ignored.
  - One transaction is outstanding at a time.
- Decode at acceptance:
  - Illegal if store with funct3 ∉ {000,001,010}, or load with funct3 ∈ {011,110,111}.
  - Misaligned if halfword with `addr[0]`=1, or word with `addr[1:0]`≠00.
  - Fault = illegal || misaligned.
  - Address bits above `ADDR_W+1` are ignored (wrap-around; no range check).
- Store lane generation (`o` = `addr[1:0]`):
  - SB: mask = 0001<<o; data = byte replicated to all 4 lanes.
  - SH: mask = 0011 when o=00, 1100 when o=10; data = halfword replicated to both halves.
  - SW: mask = 1111; data = wdata.
- FSM states:
  - IDLE: on accept, fault → RESP; store → WRITE; load → READ with count = `MEM_RD_LAT`. `mem_addr` is loaded at accept.
  - WRITE: exactly one cycle with `mem_wr`=1 and mask/data valid → RESP. `mem_wr`=0 in every other state.
  - READ: `mem_wr`=0, `mem_masked`=0, `mem_addr` held. Count decrements each cycle. When it reaches 0, `mem_r_data` is captured and extended → RESP. The total READ duration is `MEM_RD_LAT` cycles.
  - RESP: `resp_valid`=1 for exactly one cycle → IDLE. `resp_rdata` / `resp_fault` hold their values until the next RESP.
- Load extraction from the captured word at byte offset `o`:
  - LB / LBU: byte `o`, sign- or zero-extended.
  - LH / LHU: halfword `o[1]`, sign- or zero-extended.
  - LW: whole word.
- Latency, acceptance edge to `resp_valid` high:
  - Store: 2 cycles.
  - Load: `MEM_RD_LAT`+1 cycles.
  - Fault: 1 cycle, with no memory access (`mem_wr` never asserts).
- Back-to-back: the earliest next accept is the cycle after RESP. `req_valid` held high throughout is accepted then.
- A faulting store must never assert `mem_wr` or a nonzero mask.

Decomposition:
- Package `lsu_pkg`:
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - enum `lsu_state_t` {IDLE, WRITE, READ, RESP}.
  - function `lane_mask(funct3, offset)`.
- Sub-module `load_extend`: combinational extraction and extension of (word, funct3, offset) → 32-bit result. It is shared later by any other load path.

Test Plan:
- SB, addr=0x5, wdata=0x0000000E → WRITE cycle with `mem_addr`=1, `mem_masked`=0010, `mem_data`=0x0E0E0E0E; `resp_valid` 2 cycles after accept, `resp_fault`=0.
- Preload word 1 = 0x80F0_1234. Then:
  - LB addr 0x7 → rdata 0xFFFFFF80.
  - LBU addr 0x7 → 0x00000080.
  - LH addr 0x6 → 0xFFFF80F0.
  - LHU addr 0x4 → 0x00001234.
  - LW addr 0x4 → 0x80F01234.
  - Each response arrives `MEM_RD_LAT`+1 cycles after accept.
- SH addr 0x3 and LW addr 0x2 → `resp_fault`=1 one cycle after accept, `mem_wr` never 1, `resp_rdata`=0. Store funct3=100 → fault.
- `req_valid` held high with three queued SW requests → `req_ready` low except in IDLE; accepts spaced 3 cycles apart; the three writes land in order.
- `rst_n` pulsed low mid-READ with `MEM_RD_LAT`=3 → outputs clear asynchronously, no `resp_valid`, `req_ready`=1 after release.
- SW addr 0x20 with `ADDR_W`=3 → `mem_addr`=0 (wrap-around), `mem_masked`=1111, no fault.
